adder_accumulate_ctrl: RTL and testbench
========================================

# adder_accumulate_ctrl

Sequencing and accumulation controller for the 64-bit adder datapath. It accepts operand transactions over a valid/ready handshake and keeps a 64-bit accumulator. It drives the adder's A, B and c0 inputs from registers, captures the adder's 64-bit sum one cycle later, and presents sum, carry and signed-overflow downstream over a second valid/ready handshake. It sits directly upstream of the combinational 64-bit adder: it feeds that adder and consumes its result in the same loop.

## Interface
- CNT_W, 16, width of the completed-operation counter (wraps modulo 2^CNT_W)
- clk  input  1  rising-edge clock; single clock domain
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream operand present
- in_ready  output  1  block can accept an operand; high only in IDLE
- in_data  input  64  operand
- in_sub  input  1  1 = subtract operand from base, 0 = add
- in_clr  input  1  1 = use 0 as base instead of accumulator
- add_a  output  64  to adder A; registered
- add_b  output  64  to adder B; registered
- add_c0  output  1  to adder carry-in; registered
- add_sum  input  64  from adder 64-bit sum output; combinational function of add_a/add_b/add_c0
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- out_sum  output  64  captured sum
- out_carry  output  1  unsigned carry-out; for subtract, 1 = no borrow
- out_ovf  output  1  two's-complement signed overflow
- op_count  output  CNT_W  count of results accepted downstream

## Operation
- FSM states: IDLE, CALC, RESP. Reset state is IDLE.
- **IDLE:** in_ready=1. When in_valid=1:
  - add_a <= in_clr ? 0 : acc
  - add_b <= in_sub ? ~in_data : in_data
  - add_c0 <= in_sub
  - go to CALC
- **CALC:** in_ready=0. add_* are stable this cycle. At the closing edge:
  - acc <= add_sum
  - out_sum <= add_sum
  - out_carry <= (a63 & b63) | ((a63 | b63) & ~s63), using add_a[63], add_b[63], add_sum[63]
  - out_ovf <= (a63 == b63) & (s63 != a63)
  - out_valid <= 1
  - go to RESP
- **RESP:** out_valid=1; out_sum and flags held stable. When out_ready=1:
  - out_valid <= 0
  - op_count <= op_count + 1, wrapping to 0 after all-ones
  - go to IDLE
- **Input ignored:** in_valid is ignored in CALC and RESP, and no operand is latched there. Upstream holds its data until in_ready.
- **Hold values:** add_a, add_b and add_c0 keep their last values outside IDLE-accept edges. out_sum and the flags keep their last values after the handshake.
- **Clear behaviour:** in_clr=1 with in_sub=0 loads the accumulator with in_data exactly, through the adder.
- **No overlap:** one operation is in flight at a time; there is no pipelining across transactions.
- **Reset:** every register goes to 0 (acc, add_a, add_b, add_c0, out_sum, out_carry, out_ovf, out_valid, op_count). State goes to IDLE, so in_ready=1 while rst_n=0.
- **Reset mid-operation:** a reset asserted in CALC or RESP aborts the transaction. No result is emitted and op_count is not incremented.

## Timing
- Accept at edge N (in_valid & in_ready).
- add_* valid after edge N; the sum is sampled at edge N+1.
- out_valid is high after edge N+1, so the result is visible in the cycle following CALC: latency of 2 edges from accept.
- Minimum period is 3 cycles per operation (IDLE, CALC, RESP with out_ready=1).
- in_ready rises in the cycle after the out handshake edge.
- If out_ready is already high when out_valid rises, the handshake completes at the next edge.
- The adder path must settle within one clk period (add_* reg to add_sum to acc/out reg).

## Test plan
- **Reset:** hold rst_n=0 mid-stream, then release.
  - All outputs 0, in_ready=1, op_count=0.
  - in_valid pulsed during reset latches nothing.
- **Basic add:** acc=0, in_data=0x0FFF, sub=0, clr=0, out_ready=1.
  - out_valid 2 edges after accept; out_sum=0x0000_0000_0000_0FFF, carry=0, ovf=0, op_count=1.
- **Unsigned wrap:** clr load 0xFFFF_FFFF_FFFF_FFFF, then add 1.
  - out_sum=0, carry=1, ovf=0.
- **Signed overflow:** clr load 0x7FFF_FFFF_FFFF_FFFF, then add 1.
  - out_sum=0x8000_0000_0000_0000, ovf=1, carry=0.
- **Subtract:** clr load 5, sub 7.
  - out_sum=0xFFFF_FFFF_FFFF_FFFE, carry=0, ovf=0.
  - Then clr load 7, sub 5: out_sum=2, carry=1.
- **Backpressure:** hold out_ready=0 for 4 cycles in RESP while in_valid=1 with new data.
  - out_valid and out_sum stable; in_ready=0; no new operand latched; op_count increments exactly once after out_ready=1.
- **Reset in RESP:** assert reset while in RESP.
  - out_valid drops immediately; acc=0, op_count unchanged from pre-op value reset to 0.
  - The next add of 3 yields 3.

Source files
------------

// File: rtl/adder_accumulate_ctrl_if.sv
// Operand-in and result-out valid/ready handshakes for the adder accumulate controller.
// The slave modport is the controller's view; the master modport is the view of its environment.
interface adder_accumulate_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_sub;
  logic        in_clr;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sum;
  logic        out_carry;
  logic        out_ovf;

  modport slave (
    input  in_valid, in_data, in_sub, in_clr, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_ovf
  );

  modport master (
    output in_valid, in_data, in_sub, in_clr, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_ovf
  );
endinterface

// File: rtl/adder_accumulate_ctrl.sv
// Sequencing and accumulation controller for an external combinational 64-bit adder.
// Drives the adder operands from registers, captures the sum into the accumulator, and returns sum/carry/overflow.
//
// state | meaning
// IDLE  | in_ready high; accepts one operand and loads add_a/add_b/add_c0
// CALC  | adder operands stable; sum, carry and overflow captured at the closing edge
// RESP  | result held on the out handshake until out_ready
module adder_accumulate_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  adder_accumulate_ctrl_if.slave        bus,
  output logic [63:0]                   add_a,
  output logic [63:0]                   add_b,
  output logic                          add_c0,
  input  logic [63:0]                   add_sum,
  output logic [CNT_W-1:0]              op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q,     state_d;
  logic [63:0]        acc_q,       acc_d;
  logic [63:0]        add_a_q,     add_a_d;
  logic [63:0]        add_b_q,     add_b_d;
  logic               add_c0_q,    add_c0_d;
  logic [63:0]        out_sum_q,   out_sum_d;
  logic               out_carry_q, out_carry_d;
  logic               out_ovf_q,   out_ovf_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q,  in_ready_d;
  logic [CNT_W-1:0]   op_count_q,  op_count_d;

  logic a63, b63, s63;

  assign a63 = add_a_q[63];
  assign b63 = add_b_q[63];
  assign s63 = add_sum[63];

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_c0_d    = add_c0_q;
    out_sum_d   = out_sum_q;
    out_carry_d = out_carry_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    op_count_d  = op_count_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          add_a_d    = bus.in_clr ? 64'd0 : acc_q;
          add_b_d    = bus.in_sub ? ~bus.in_data : bus.in_data;
          add_c0_d   = bus.in_sub;
          in_ready_d = 1'b0;
          state_d    = CALC;
        end
      end
      CALC: begin
        // Carry-out is rebuilt from the MSBs since the adder only exposes a 64-bit sum.
        acc_d       = add_sum;
        out_sum_d   = add_sum;
        out_carry_d = (a63 & b63) | ((a63 | b63) & ~s63);
        out_ovf_d   = (a63 == b63) & (s63 != a63);
        out_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_c0_q    <= 1'b0;
      out_sum_q   <= '0;
      out_carry_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_c0_q    <= add_c0_d;
      out_sum_q   <= out_sum_d;
      out_carry_q <= out_carry_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      op_count_q  <= op_count_d;
    end
  end

  assign add_a         = add_a_q;
  assign add_b         = add_b_q;
  assign add_c0        = add_c0_q;
  assign op_count      = op_count_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_carry = out_carry_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_adder_accumulate_ctrl.sv
// Directed bench for adder_accumulate_ctrl with a behavioural 64-bit adder closing the loop.
module tb_adder_accumulate_ctrl;

  logic        clk;
  logic        rst_n;
  logic [63:0] add_a;
  logic [63:0] add_b;
  logic        add_c0;
  logic [63:0] add_sum;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;

  adder_accumulate_ctrl_if u_if ();

  adder_accumulate_ctrl #(.CNT_W(16)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (u_if),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_c0   (add_c0),
    .add_sum  (add_sum),
    .op_count (op_count)
  );

  assign add_sum = add_a + add_b + {63'd0, add_c0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for in_ready, presents one operand for the accept edge,
  // then waits (bounded) for the result to appear on out_valid.
  task automatic run_op(input logic [63:0] data, input logic sub, input logic clr);
    int n;
    n = 0;
    while (u_if.in_ready !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk("in_ready_wait", 64'(u_if.in_ready), 64'd1);
    u_if.in_valid = 1'b1;
    u_if.in_data  = data;
    u_if.in_sub   = sub;
    u_if.in_clr   = clr;
    step();
    u_if.in_valid = 1'b0;
    n = 0;
    while (u_if.out_valid !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk("out_valid_wait", 64'(u_if.out_valid), 64'd1);
  endtask

  initial begin
    rst_n          = 1'b0;
    u_if.in_valid  = 1'b0;
    u_if.in_data   = 64'd0;
    u_if.in_sub    = 1'b0;
    u_if.in_clr    = 1'b0;
    u_if.out_ready = 1'b0;

    // Reset with an operand offered: nothing may be latched.
    #2;
    u_if.in_valid = 1'b1;
    u_if.in_data  = 64'h1111;
    u_if.in_clr   = 1'b1;
    step();
    step();
    chk("rst_in_ready",  64'(u_if.in_ready),  64'd1);
    chk("rst_out_valid", 64'(u_if.out_valid), 64'd0);
    chk("rst_add_b",     add_b,               64'd0);
    u_if.in_valid = 1'b0;
    u_if.in_clr   = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("rel_add_a",     add_a,               64'd0);
    chk("rel_add_b",     add_b,               64'd0);
    chk("rel_add_c0",    64'(add_c0),         64'd0);
    chk("rel_out_sum",   u_if.out_sum,        64'd0);
    chk("rel_carry",     64'(u_if.out_carry), 64'd0);
    chk("rel_ovf",       64'(u_if.out_ovf),   64'd0);
    chk("rel_op_count",  64'(op_count),       64'd0);
    chk("rel_in_ready",  64'(u_if.in_ready),  64'd1);

    // Basic add with explicit latency checks.
    u_if.out_ready = 1'b1;
    u_if.in_valid  = 1'b1;
    u_if.in_data   = 64'h0FFF;
    step();
    u_if.in_valid = 1'b0;
    chk("add_calc_in_ready",  64'(u_if.in_ready),  64'd0);
    chk("add_calc_out_valid", 64'(u_if.out_valid), 64'd0);
    chk("add_calc_add_b",     add_b,               64'h0FFF);
    chk("add_calc_add_c0",    64'(add_c0),         64'd0);
    step();
    chk("add_resp_out_valid", 64'(u_if.out_valid), 64'd1);
    chk("add_sum",            u_if.out_sum,        64'h0000_0000_0000_0FFF);
    chk("add_carry",          64'(u_if.out_carry), 64'd0);
    chk("add_ovf",            64'(u_if.out_ovf),   64'd0);
    step();
    chk("add_op_count",       64'(op_count),       64'd1);
    chk("add_done_out_valid", 64'(u_if.out_valid), 64'd0);
    chk("add_done_in_ready",  64'(u_if.in_ready),  64'd1);
    chk("add_hold_sum",       u_if.out_sum,        64'h0FFF);

    // Unsigned wrap.
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    chk("load_ones_sum",   u_if.out_sum,        64'hFFFF_FFFF_FFFF_FFFF);
    chk("load_ones_carry", 64'(u_if.out_carry), 64'd0);
    step();
    run_op(64'd1, 1'b0, 1'b0);
    chk("wrap_sum",   u_if.out_sum,        64'd0);
    chk("wrap_carry", 64'(u_if.out_carry), 64'd1);
    chk("wrap_ovf",   64'(u_if.out_ovf),   64'd0);
    step();

    // Signed overflow.
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    chk("load_max_ovf", 64'(u_if.out_ovf), 64'd0);
    step();
    run_op(64'd1, 1'b0, 1'b0);
    chk("sovf_sum",   u_if.out_sum,        64'h8000_0000_0000_0000);
    chk("sovf_ovf",   64'(u_if.out_ovf),   64'd1);
    chk("sovf_carry", 64'(u_if.out_carry), 64'd0);
    step();

    // Subtract both directions.
    run_op(64'd5, 1'b0, 1'b1);
    step();
    run_op(64'd7, 1'b1, 1'b0);
    chk("sub57_add_b",  add_b,               64'hFFFF_FFFF_FFFF_FFF8);
    chk("sub57_add_c0", 64'(add_c0),         64'd1);
    chk("sub57_sum",    u_if.out_sum,        64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub57_carry",  64'(u_if.out_carry), 64'd0);
    chk("sub57_ovf",    64'(u_if.out_ovf),   64'd0);
    step();
    run_op(64'd7, 1'b0, 1'b1);
    step();
    run_op(64'd5, 1'b1, 1'b0);
    chk("sub75_sum",   u_if.out_sum,        64'd2);
    chk("sub75_carry", 64'(u_if.out_carry), 64'd1);
    chk("sub75_ovf",   64'(u_if.out_ovf),   64'd0);
    step();
    chk("pre_bp_op_count", 64'(op_count), 64'd9);

    // Backpressure in RESP with a new operand offered.
    u_if.out_ready = 1'b0;
    run_op(64'h1234, 1'b0, 1'b1);
    u_if.in_valid = 1'b1;
    u_if.in_data  = 64'hDEAD;
    u_if.in_clr   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_out_valid", 64'(u_if.out_valid), 64'd1);
      chk("bp_out_sum",   u_if.out_sum,        64'h1234);
      chk("bp_in_ready",  64'(u_if.in_ready),  64'd0);
      chk("bp_add_b",     add_b,               64'h1234);
      chk("bp_op_count",  64'(op_count),       64'd9);
    end
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    step();
    chk("bp_done_op_count",  64'(op_count),       64'd10);
    chk("bp_done_out_valid", 64'(u_if.out_valid), 64'd0);
    chk("bp_done_add_b",     add_b,               64'h1234);
    step();
    chk("bp_idle_op_count",  64'(op_count),       64'd10);

    // Reset while in RESP aborts the transaction.
    u_if.out_ready = 1'b0;
    run_op(64'h10, 1'b0, 1'b0);
    chk("rresp_sum", u_if.out_sum, 64'h1244);
    rst_n = 1'b0;
    #1;
    chk("rresp_out_valid", 64'(u_if.out_valid), 64'd0);
    chk("rresp_op_count",  64'(op_count),       64'd0);
    chk("rresp_in_ready",  64'(u_if.in_ready),  64'd1);
    chk("rresp_out_sum",   u_if.out_sum,        64'd0);
    step();
    rst_n          = 1'b1;
    u_if.out_ready = 1'b1;
    step();
    run_op(64'd3, 1'b0, 1'b0);
    chk("post_rst_sum", u_if.out_sum, 64'd3);
    step();
    chk("post_rst_op_count", 64'(op_count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
